dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 The block SHALL take parameter DEPTH_WORDS, default 256: storage depth in 32-bit words, a power of two from 16 to 4096.
REQ-003 The block SHALL take parameter LATENCY, default 2: WAIT-state cycles per legal access, 1 to 15.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_write_mem  input  2  store encoding: 00 none, 01 SB, 10 SH, 11 SW.
REQ-011 req_read_mem  input  3  load encoding: 000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW; 110 and 111 are illegal.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  initiator accepts the response.
REQ-014 rsp_rdata  output  32  sign- or zero-extended load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  request rejected; storage unchanged.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE, and rsp_valid SHALL be 1 only in RESP.
REQ-017 A request SHALL be accepted on a clk edge where req_valid and req_ready are both 1; addr, wdata and both encodings SHALL be registered on that edge.
REQ-018 An accepted request SHALL be an error when any of the following holds:
- both encodings are nonzero, or both are zero;
- the load encoding is illegal;
- a halfword access has addr[0] = 1, or a word access has addr[1:0] != 00;
- addr[31:2] >= DEPTH_WORDS.
REQ-019 An error request SHALL go IDLE -> RESP with rsp_err = 1 and rsp_rdata = 0, and SHALL NOT modify storage.
REQ-020 A legal request SHALL go IDLE -> WAIT and load the wait counter with LATENCY-1; in WAIT the counter SHALL decrement each cycle, and on the edge where it equals 0 the state SHALL go WAIT -> RESP.
- rsp_valid therefore rises LATENCY+1 edges after the accept edge.
REQ-021 A store SHALL commit only on the WAIT -> RESP edge, with byte enables derived from addr[1:0] and size; unselected bytes SHALL be unchanged.
REQ-022 A load SHALL read on the WAIT -> RESP edge; the addressed byte or halfword SHALL be shifted to bit 0 and sign-extended (LB, LH) or zero-extended (LBU, LHU).
REQ-023 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready = 1; it SHALL then go to IDLE on that edge.
- rsp_ready SHALL be ignored outside RESP.
REQ-024 A new request SHALL be accepted no earlier than the cycle after the RESP -> IDLE edge, with no back-to-back overlap.
REQ-025 req_* changes while req_ready = 0 SHALL have no effect.

Reset
REQ-026 While rst = 0, the block SHALL hold: state IDLE, counter 0, req_ready 1 one cycle after release (0 while rst is low), rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-027 Reset asserted in WAIT SHALL drop the pending store uncommitted; reset asserted in RESP SHALL drop the response.
REQ-028 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-029 Package dmem_pkg SHALL hold the write_mem and read_mem encodings, the FSM state enum, and the error-check helper.
REQ-030 Sub-module dmem_lane_align (combinational) SHALL produce the store byte-enable and merged word, and the load extract/extend; the FSM, counter and storage array SHALL reside in dmem_responder.

Verification
REQ-031 Reset, then SW 0x12345678 @0x10, then LW @0x10 -> rdata 0x12345678, err 0; rsp_valid rises 3 edges after each accept (LATENCY 2).
REQ-032 Word 0x8081F0FF @0x20; LB @0x22 -> 0xFFFFFF81; LBU @0x22 -> 0x00000081; LH @0x20 -> 0xFFFFF0FF; LHU @0x22 -> 0x00008081.
REQ-033 SB 0xAA @0x21 over 0x11223344 -> LW @0x20 returns 0x1122AA44.
REQ-034 Errors: SH @0x03 -> err 1, 1-edge latency, storage unchanged; LW @(DEPTH_WORDS*4) -> err 1; write_mem 11 with read_mem 101 -> err 1.
REQ-035 Hold rsp_ready 0 for 5 cycles -> rsp_valid, rdata and err stable, req_ready 0; one cycle of rsp_ready 1 -> IDLE.
REQ-036 SW 0xDEADBEEF @0x30 with rst pulsed low during WAIT -> outputs at reset values, a later LW @0x30 returns the prior contents, and storage is otherwise unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and request legality check for the
// data-memory responder.
package dmem_pkg;

    localparam logic [1:0] WM_NONE = 2'b00;
    localparam logic [1:0] WM_SB   = 2'b01;
    localparam logic [1:0] WM_SH   = 2'b10;
    localparam logic [1:0] WM_SW   = 2'b11;

    localparam logic [2:0] RM_NONE = 3'b000;
    localparam logic [2:0] RM_LB   = 3'b001;
    localparam logic [2:0] RM_LBU  = 3'b010;
    localparam logic [2:0] RM_LH   = 3'b011;
    localparam logic [2:0] RM_LHU  = 3'b100;
    localparam logic [2:0] RM_LW   = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // A request is rejected for ambiguous/illegal encoding, misalignment or
    // an out-of-range word index.
    function automatic logic is_req_err(input logic [1:0]  write_mem,
                                        input logic [2:0]  read_mem,
                                        input logic [31:0] addr,
                                        input logic [31:0] depth_words);
        logic is_half;
        logic is_word;
        logic err;
        is_half = (write_mem == WM_SH) || (read_mem == RM_LH) || (read_mem == RM_LHU);
        is_word = (write_mem == WM_SW) || (read_mem == RM_LW);
        err = 1'b0;
        if ((write_mem != WM_NONE) == (read_mem != RM_NONE)) begin
            err = 1'b1;
        end else if (read_mem > RM_LW) begin
            err = 1'b1;
        end else if (is_half && addr[0]) begin
            err = 1'b1;
        end else if (is_word && (addr[1:0] != 2'b00)) begin
            err = 1'b1;
        end else if ((addr >> 2) >= depth_words) begin
            err = 1'b1;
        end else begin
            err = 1'b0;
        end
        return err;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables and merged word, load extract/extend.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  write_mem,
    input  logic [2:0]  read_mem,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [3:0]  byte_en,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);

    logic [31:0] rep_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store path: replicate the store data across lanes, enable only the addressed ones
    always_comb begin
        byte_en     = 4'b0000;
        rep_s       = wdata;
        merged_word = old_word;
        case (write_mem)
            WM_SB: begin
                byte_en = 4'b0001 << addr_lo;
                rep_s   = {4{wdata[7:0]}};
            end
            WM_SH: begin
                byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                rep_s   = {2{wdata[15:0]}};
            end
            WM_SW: begin
                byte_en = 4'b1111;
                rep_s   = wdata;
            end
            default: begin
                byte_en = 4'b0000;
                rep_s   = wdata;
            end
        endcase
        for (int b = 0; b < 4; b++) begin
            merged_word[8*b +: 8] = byte_en[b] ? rep_s[8*b +: 8] : old_word[8*b +: 8];
        end
    end

    // Load path: shift addressed lane to bit 0 and extend
    always_comb begin
        byte_s    = 8'(old_word >> {addr_lo, 3'b000});
        half_s    = addr_lo[1] ? old_word[31:16] : old_word[15:0];
        load_data = 32'h0000_0000;
        case (read_mem)
            RM_LB:   load_data = {{24{byte_s[7]}}, byte_s};
            RM_LBU:  load_data = {24'h00_0000, byte_s};
            RM_LH:   load_data = {{16{half_s[15]}}, half_s};
            RM_LHU:  load_data = {16'h0000, half_s};
            RM_LW:   load_data = old_word;
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Request/response data-memory slave: IDLE/WAIT/RESP handshake FSM with a
// programmable access latency over a word-organised storage array.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_write_mem,
    input  logic [2:0]  req_read_mem,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_r [DEPTH_WORDS];
    state_t        state_r, state_s;
    logic [3:0]    cnt_r, cnt_s;
    logic [AW+1:0] addr_r;
    logic [31:0]   wdata_r;
    logic [1:0]    wm_r;
    logic [2:0]    rm_r;
    logic          ready_r, valid_r, err_r;
    logic [31:0]   rdata_r;

    logic          accept_s, req_err_s, finish_s;
    logic [31:0]   old_word_s, merged_s, load_s;
    logic [3:0]    byte_en_s;

    assign accept_s   = req_valid && ready_r && (state_r == ST_IDLE);
    assign req_err_s  = is_req_err(req_write_mem, req_read_mem, req_addr, 32'(DEPTH_WORDS));
    assign finish_s   = (state_r == ST_WAIT) && (cnt_r == 4'd0);
    assign old_word_s = mem_r[addr_r[AW+1:2]];

    dmem_lane_align u_lane (
        .addr_lo     (addr_r[1:0]),
        .write_mem   (wm_r),
        .read_mem    (rm_r),
        .wdata       (wdata_r),
        .old_word    (old_word_s),
        .byte_en     (byte_en_s),
        .merged_word (merged_s),
        .load_data   (load_s)
    );

    // Next-state and wait-counter logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && req_err_s) begin
                    state_s = ST_RESP;
                end else if (accept_s) begin
                    state_s = ST_WAIT;
                    cnt_s   = 4'(LATENCY - 1);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // FSM state, captured request and registered response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
            wm_r    <= WM_NONE;
            rm_r    <= RM_NONE;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ready_r <= (state_s == ST_IDLE);
            valid_r <= (state_s == ST_RESP);
            if (accept_s) begin
                addr_r  <= req_addr[AW+1:0];
                wdata_r <= req_wdata;
                wm_r    <= req_write_mem;
                rm_r    <= req_read_mem;
            end
            if (accept_s && req_err_s) begin
                rdata_r <= 32'h0000_0000;
                err_r   <= 1'b1;
            end else if (finish_s) begin
                rdata_r <= load_s;
                err_r   <= 1'b0;
            end else if ((state_r == ST_RESP) && rsp_ready) begin
                rdata_r <= 32'h0000_0000;
                err_r   <= 1'b0;
            end
        end
    end

    // Storage is never reset; stores commit only on the WAIT -> RESP edge
    always_ff @(posedge clk) begin
        if (rst && finish_s && (|byte_en_s)) begin
            mem_r[addr_r[AW+1:2]] <= merged_s;
        end
    end

    assign req_ready = ready_r;
    assign rsp_valid = valid_r;
    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;

endmodule
